// File: rtl/tc_sram_latch_mp.sv
// N-port latch-array memory: registered reads, one staged write per port, lane-merged conflicts.
// Define TC_SRAM_LATCH_FWD_EN to forward same-cycle writes to reads of the same word.
module tc_sram_latch_mp #(
   parameter  int unsigned NumWords  = 32,
   parameter  int unsigned DataWidth = 64,
   parameter  int unsigned ByteWidth = 8,
   parameter  int unsigned NumPorts  = 2,
   localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
   localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [NumPorts-1:0]            req_i,
   input  logic [NumPorts-1:0]            we_i,
   input  logic [NumPorts*AddrWidth-1:0]  addr_i,
   input  logic [NumPorts*DataWidth-1:0]  wdata_i,
   input  logic [NumPorts*BeWidth-1:0]    be_i,
   output logic [NumPorts*DataWidth-1:0]  rdata_o,
   output logic [NumPorts-1:0]            rvalid_o
);

   localparam int unsigned PadWidth = BeWidth * ByteWidth;

   logic [NumPorts-1:0]  stg_valid_d, stg_valid_q;
   logic [AddrWidth-1:0] stg_addr_d  [NumPorts];
   logic [AddrWidth-1:0] stg_addr_q  [NumPorts];
   logic [PadWidth-1:0]  stg_wdata_d [NumPorts];
   logic [PadWidth-1:0]  stg_wdata_q [NumPorts];
   logic [BeWidth-1:0]   stg_be_d    [NumPorts];
   logic [BeWidth-1:0]   stg_be_q    [NumPorts];

   logic [DataWidth-1:0] rdata_d [NumPorts];
   logic [DataWidth-1:0] rdata_q [NumPorts];
   logic [NumPorts-1:0]  rvalid_d, rvalid_q;

   logic [PadWidth-1:0]  wdata_pad [NumPorts];
   logic [ByteWidth-1:0] mem       [NumWords][BeWidth];
   logic [BeWidth-1:0]   lat_en    [NumWords];
   logic [ByteWidth-1:0] lat_data  [NumWords][BeWidth];

   logic [AddrWidth-1:0] rd_addr;
   logic [ByteWidth-1:0] rd_lane;
   logic [PadWidth-1:0]  rd_pad;

   always_comb begin
      for (int p = 0; p < NumPorts; p++) begin
         wdata_pad[p]   = PadWidth'(wdata_i[p*DataWidth +: DataWidth]);
         stg_valid_d[p] = req_i[p] & we_i[p];
         stg_addr_d[p]  = stg_addr_q[p];
         stg_wdata_d[p] = stg_wdata_q[p];
         stg_be_d[p]    = stg_be_q[p];
         if (req_i[p] && we_i[p]) begin
            stg_addr_d[p]  = addr_i[p*AddrWidth +: AddrWidth];
            stg_wdata_d[p] = wdata_pad[p];
            stg_be_d[p]    = be_i[p*BeWidth +: BeWidth];
         end
      end
   end

   // Per word/lane enable from the stage; descending loop so the lowest port wins each lane.
   always_comb begin
      for (int w = 0; w < NumWords; w++) begin
         for (int b = 0; b < BeWidth; b++) begin
            lat_en[w][b]   = 1'b0;
            lat_data[w][b] = '0;
            for (int p = NumPorts - 1; p >= 0; p--) begin
               if (stg_valid_q[p] && stg_addr_q[p] == AddrWidth'(w) && stg_be_q[p][b]) begin
                  lat_en[w][b]   = 1'b1;
                  lat_data[w][b] = stg_wdata_q[p][b*ByteWidth +: ByteWidth];
               end
            end
         end
      end
   end

   // Latches open in the low phase of the cycle after capture; stage data is stable there.
   always_latch begin
      for (int w = 0; w < NumWords; w++) begin
         for (int b = 0; b < BeWidth; b++) begin
            if (lat_en[w][b] && !clk_i) mem[w][b] <= lat_data[w][b];
         end
      end
   end

   always_comb begin
      rd_addr = '0;
      rd_lane = '0;
      rd_pad  = '0;
      for (int p = 0; p < NumPorts; p++) begin
         rdata_d[p]  = rdata_q[p];
         rvalid_d[p] = 1'b0;
         if (req_i[p] && !we_i[p]) begin
            rvalid_d[p] = 1'b1;
            rd_addr     = addr_i[p*AddrWidth +: AddrWidth];
            rd_pad      = '0;
            if (32'(rd_addr) < NumWords) begin
               for (int b = 0; b < BeWidth; b++) begin
                  rd_lane = mem[rd_addr][b];
                  for (int q = NumPorts - 1; q >= 0; q--) begin
                     if (stg_valid_q[q] && stg_addr_q[q] == rd_addr && stg_be_q[q][b])
                        rd_lane = stg_wdata_q[q][b*ByteWidth +: ByteWidth];
                  end
`ifdef TC_SRAM_LATCH_FWD_EN
                  for (int q = NumPorts - 1; q >= 0; q--) begin
                     if (req_i[q] && we_i[q] && addr_i[q*AddrWidth +: AddrWidth] == rd_addr
                         && be_i[q*BeWidth + b])
                        rd_lane = wdata_pad[q][b*ByteWidth +: ByteWidth];
                  end
`endif
                  rd_pad[b*ByteWidth +: ByteWidth] = rd_lane;
               end
            end
            rdata_d[p] = rd_pad[DataWidth-1:0];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stg_valid_q <= '0;
         rvalid_q    <= '0;
         for (int p = 0; p < NumPorts; p++) begin
            stg_addr_q[p]  <= '0;
            stg_wdata_q[p] <= '0;
            stg_be_q[p]    <= '0;
            rdata_q[p]     <= '0;
         end
      end else begin
         stg_valid_q <= stg_valid_d;
         rvalid_q    <= rvalid_d;
         for (int p = 0; p < NumPorts; p++) begin
            stg_addr_q[p]  <= stg_addr_d[p];
            stg_wdata_q[p] <= stg_wdata_d[p];
            stg_be_q[p]    <= stg_be_d[p];
            rdata_q[p]     <= rdata_d[p];
         end
      end
   end

   always_comb begin
      for (int p = 0; p < NumPorts; p++) rdata_o[p*DataWidth +: DataWidth] = rdata_q[p];
      rvalid_o = rvalid_q;
   end

endmodule

// File: tb/tb_tc_sram_latch_mp.sv
// Scoreboard bench for tc_sram_latch_mp (2 ports, 20 words, 64-bit, byte lanes).
module tb_tc_sram_latch_mp;
   localparam int NW = 20;
   localparam int AW = 5;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic [1:0]   req, we;
   logic [AW-1:0] addr  [2];
   logic [63:0]  wdata [2];
   logic [7:0]   be    [2];
   logic [127:0] rdata_o;
   logic [1:0]   rvalid_o;

   logic [63:0]  model  [NW];
   logic [63:0]  last_rd [2];
   logic [63:0]  exp_q0 [$];
   logic [63:0]  exp_q1 [$];
   int           n_tests = 0;
   int           n_fail  = 0;

   always #5 clk_i = ~clk_i;

   tc_sram_latch_mp #(.NumWords(NW), .DataWidth(64), .ByteWidth(8), .NumPorts(2)) dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .req_i    (req),
      .we_i     (we),
      .addr_i   ({addr[1], addr[0]}),
      .wdata_i  ({wdata[1], wdata[0]}),
      .be_i     ({be[1], be[0]}),
      .rdata_o  (rdata_o),
      .rvalid_o (rvalid_o)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model_read(input int p);
      logic [63:0] v;
      if (addr[p] >= AW'(NW)) return 64'h0;
      v = model[addr[p]];
`ifdef TC_SRAM_LATCH_FWD_EN
      for (int q = 1; q >= 0; q--)
         if (req[q] && we[q] && addr[q] == addr[p])
            for (int b = 0; b < 8; b++)
               if (be[q][b]) v[b*8 +: 8] = wdata[q][b*8 +: 8];
`endif
      return v;
   endfunction

   task automatic clear_inputs();
      req = '0; we = '0;
      for (int p = 0; p < 2; p++) begin addr[p] = '0; wdata[p] = '0; be[p] = '0; end
   endtask

   task automatic set_wr(input int p, input int a, input logic [63:0] d, input logic [7:0] b);
      req[p] = 1'b1; we[p] = 1'b1; addr[p] = AW'(a); wdata[p] = d; be[p] = b;
   endtask

   task automatic set_rd(input int p, input int a);
      req[p] = 1'b1; we[p] = 1'b0; addr[p] = AW'(a);
   endtask

   // Called just after a negedge with inputs set; returns just after the next negedge.
   task automatic step();
      logic [1:0]  rd;
      logic [63:0] e;
      for (int p = 0; p < 2; p++) begin
         rd[p] = req[p] & ~we[p];
         if (rd[p]) begin
            if (p == 0) exp_q0.push_back(model_read(p));
            else        exp_q1.push_back(model_read(p));
         end
      end
      for (int p = 1; p >= 0; p--)
         if (req[p] && we[p] && addr[p] < AW'(NW))
            for (int b = 0; b < 8; b++)
               if (be[p][b]) model[addr[p]][b*8 +: 8] = wdata[p][b*8 +: 8];
      @(posedge clk_i); #1;
      for (int p = 0; p < 2; p++) begin
         check_eq($sformatf("rvalid%0d", p), 64'(rvalid_o[p]), 64'(rd[p]));
         if (rd[p]) begin
            check_eq($sformatf("sb_nonempty%0d", p),
                     64'((p == 0) ? exp_q0.size() : exp_q1.size()), 64'd1);
            e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check_eq($sformatf("rdata%0d", p), rdata_o[p*64 +: 64], e);
            last_rd[p] = e;
         end else begin
            check_eq($sformatf("rdata_hold%0d", p), rdata_o[p*64 +: 64], last_rd[p]);
         end
      end
      @(negedge clk_i);
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      rst_ni = 1'b0;
      last_rd[0] = '0; last_rd[1] = '0;
      repeat (3) @(negedge clk_i);
      check_eq("rst_rvalid", 64'(rvalid_o), 64'd0);
      check_eq("rst_rdata", rdata_o[63:0] | rdata_o[127:64], 64'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      for (int w = 0; w < NW; w += 2) begin
         set_wr(0, w,     64'hC0DE_0000_0000_0000 | 64'(w) | (64'(w) << 40), 8'hFF);
         set_wr(1, w + 1, 64'hC0DE_0000_0000_0000 | 64'(w + 1) | (64'(w + 1) << 40), 8'hFF);
         step();
      end
      for (int w = 0; w < NW; w++) begin set_rd(0, w); set_rd(1, NW - 1 - w); step(); end

      // byte-enable merge on word 5
      set_wr(0, 5, 64'h1122_3344_5566_7788, 8'hFF); step();
      set_wr(0, 5, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F); step();
      set_rd(0, 5); step();
      check_eq("be_const", last_rd[0], 64'h1122_3344_AAAA_AAAA);

      // read on the cycle right after a write
      set_wr(1, 3, 64'hDEAD, 8'hFF); step();
      set_rd(0, 3); step();
      check_eq("raw_const", last_rd[0], 64'hDEAD);

      // same-cycle conflict on word 7
      set_wr(0, 7, 64'h0000_0000_0000_00FF, 8'h01);
      set_wr(1, 7, 64'hFFFF_FFFF_FFFF_FFEE, 8'h03); step();
      set_rd(1, 7); step();
      check_eq("conflict_lo16", {48'h0, last_rd[1][15:0]}, 64'hFFFF);

      // same-cycle read/write on word 9
      set_wr(0, 9, 64'h1, 8'hFF); step();
      step();
      set_wr(0, 9, 64'h2, 8'hFF); set_rd(1, 9); step();
`ifdef TC_SRAM_LATCH_FWD_EN
      check_eq("rw_same_cycle", last_rd[1], 64'h2);
`else
      check_eq("rw_same_cycle", last_rd[1], 64'h1);
`endif
      set_rd(0, 9); step();

      // back-to-back writes to one word
      set_wr(0, 12, 64'h0102_0304_0506_0708, 8'hFF); step();
      set_wr(1, 12, 64'hFFFF_FFFF_FFFF_FFFF, 8'h81); step();
      set_wr(0, 12, 64'h0000_0000_0000_0055, 8'h01); set_rd(1, 12); step();
      set_rd(0, 12); step();

      // out of range
      set_wr(0, 25, 64'hBADB_ADBA_DBAD_BADB, 8'hFF); set_wr(1, 31, 64'h1234, 8'hFF); step();
      set_rd(1, 25); set_rd(0, 20); step();
      for (int w = 0; w < NW; w++) begin set_rd(0, w); step(); end

      // reset with a staged write in flight
      set_wr(0, 11, 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF);
      @(posedge clk_i); #1;
      rst_ni = 1'b0;
      clear_inputs();
      #1;
      check_eq("rst_mid_rvalid", 64'(rvalid_o), 64'd0);
      check_eq("rst_mid_rdata0", rdata_o[63:0], 64'd0);
      check_eq("rst_mid_rdata1", rdata_o[127:64], 64'd0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      last_rd[0] = '0; last_rd[1] = '0;
      step();
      set_rd(0, 11); step();

      // random traffic
      for (int i = 0; i < 300; i++) begin
         for (int p = 0; p < 2; p++) begin
            req[p]   = ($urandom_range(3) != 0);
            we[p]    = $urandom_range(1) == 1;
            addr[p]  = AW'($urandom_range(23));
            wdata[p] = {$urandom, $urandom};
            be[p]    = 8'($urandom);
         end
         step();
      end
      for (int w = 0; w < NW; w += 2) begin set_rd(0, w); set_rd(1, w + 1); step(); end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/tc_sram_latch_mp.md
Name: tc_sram_latch_mp

Overview:
- Parametrised N-port latch-based memory macro with the tc_sram-style request interface.
- Honours req_i and per-byte be_i.
- Registered 1-cycle reads with rvalid_o; write staging stage with mandatory forwarding; deterministic multi-port write-conflict resolution.
- Drop-in target for small tables (IOPMP entry/MDCFG arrays) where flop arrays cost too much area.

Parameters:
- NumWords, 32, number of words in the array (need not be a power of 2).
- DataWidth, 64, word width in bits.
- ByteWidth, 8, bits per byte-enable lane.
- NumPorts, 2, number of independent read/write ports (1..4).
- AddrWidth, derived, (NumWords>1) ? $clog2(NumWords) : 1; do not override.
- BeWidth, derived, ceil(DataWidth/ByteWidth); do not override.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  NumPorts  per-port request strobe.
- we_i  in  NumPorts  per-port write enable (1=write, 0=read); ignored unless req_i.
- addr_i  in  NumPorts*AddrWidth  per-port word address.
- wdata_i  in  NumPorts*DataWidth  per-port write data.
- be_i  in  NumPorts*BeWidth  per-port byte enable; lane b covers bits [b*ByteWidth +: ByteWidth], last lane may be partial.
- rdata_o  out  NumPorts*DataWidth  per-port registered read data.
- rvalid_o  out  NumPorts  per-port 1-cycle pulse, rdata_o updated this cycle.

Behaviour:
- Reset (rst_ni=0, async): rdata_o=0, rvalid_o=0, write stage valid=0; pending staged write discarded. Array contents not reset; undefined after power-up.
- Read: req_i[p]&~we_i[p] sampled at edge T, then rdata_o[p] valid and rvalid_o[p]=1 in cycle T+1.
  - rdata_o[p] holds its value until the next read on port p; write-only cycles never change rdata_o.
- Write stage: req_i[p]&we_i[p] at edge T captures addr/data/be into the port's stage register (valid=1).
  - During cycle T+1 the target word latches open for the enabled lanes only (gated clock, one latch-enable per word per lane).
  - New data is in the array by edge T+2. be_i=0 performs no array change.
- Stage forwarding (always on): a read sampled at T+1 to an address with a valid stage entry returns the array word merged per lane with staged data. Read-after-write on consecutive cycles is therefore always coherent.
- Same-cycle multi-write, same address: merged per lane; for each lane the lowest-index port with that lane enabled wins. Back-to-back writes to the same word on consecutive cycles apply in order.
- Same-cycle read and write, same address, different ports: read returns pre-write data (see optional feature).
- Out of range (addr >= NumWords): write dropped with no array change; read returns 0 with rvalid_o=1.
- Throughput: one request per port per cycle, no stalls, no backpressure, no gnt signal.
- No combinational path from any input to any output.

Optional Feature:
- Macro TC_SRAM_LATCH_FWD_EN.
- Defined: same-cycle write forwarding. A read at edge T to an address written at edge T by any port returns the lane-merged new data (lowest-index port wins per lane), the same result a read at T+1 would see.
- Undefined: the read returns pre-write data. Forwarding logic is absent; area and timing match the base block.

Test Plan:
- Reset: assert rst_ni=0 mid-stream with a write staged, release, read same address -> rdata_o=0 and rvalid_o=0 during reset; the aborted write is not visible (array unchanged from prior known value).
- Byte-enable write: port0 write addr 5 data 0x1122334455667788 be=0xFF, then port0 write addr 5 data 0xAAAAAAAAAAAAAAAA be=0x0F, read addr 5 -> 0x11223344AAAAAAAA, rvalid_o[0] one cycle after the read request.
- Read-after-write next cycle: port1 write addr 3 data 0xDEAD at T, port0 read addr 3 at T+1 -> rdata_o[0]=0xDEAD at T+2 (stage forwarding).
- Write conflict: port0 write addr 7 0x00000000000000FF be=0x01 and port1 write addr 7 0xFFFFFFFFFFFFFFEE be=0x03 same cycle -> readback 0x00000000000000FF in byte0 and 0xFF in byte1.
- Same-cycle read/write: addr 9 holds 0x1, port0 writes 0x2 while port1 reads addr 9 -> rdata_o[1]=0x1 without the macro, 0x2 with TC_SRAM_LATCH_FWD_EN.
- Out of range with NumWords=20: write addr 25 then read addr 25 -> rdata_o=0, rvalid_o=1; words 0..19 unchanged.
